// File: rtl/dmem_ws.sv
// Word-organised data memory with a configurable number of wait states and byte-lane writes.
// Optional build macro DMEM_MISALIGN_EN adds MisalignM and rejects misaligned word/halfword requests.
module dmem_ws #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [3:0]  ByteEnM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM
`ifdef DMEM_MISALIGN_EN
    ,
    output logic        MisalignM
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wordIdx;
    logic          req;
    logic          misalign;
    logic          reqOk;
    logic          commit;
    logic          unused_ok;

    assign wordIdx = DataAdrM[AW+1:2];
    assign req     = MemReadM | MemWriteM;
    assign reqOk   = req & ~misalign;

`ifdef DMEM_MISALIGN_EN
    assign misalign = req &
                      (((ByteEnM == 4'b1111) & (DataAdrM[1:0] != 2'b00)) |
                       (((ByteEnM == 4'b0011) | (ByteEnM == 4'b1100)) & DataAdrM[0]));
    assign MisalignM = misalign & ~reset;
    assign unused_ok = ^{DataAdrM[31:AW+2], req, reqOk};
`else
    assign misalign  = 1'b0;
    assign unused_ok = ^{DataAdrM[31:AW+2], DataAdrM[1:0], req, reqOk};
`endif

    generate
        if (WAIT == 0) begin : g_nowait
            assign StallM = 1'b0;
            assign commit = MemWriteM & ~misalign & ~reset;
        end else begin : g_wait
            typedef enum logic {IDLE, BUSY} state_t;

            localparam logic [3:0] WaitCnt = 4'(WAIT);

            state_t     state_q;
            logic [3:0] cnt_q;
            logic       done;

            // The access completes in the cycle the counter has reached WAIT while still requested.
            assign done   = (state_q == BUSY) & (cnt_q == WaitCnt);
            assign StallM = reqOk & ~done & ~reset;
            assign commit = done & reqOk & MemWriteM & ~reset;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (reqOk) begin
                                state_q <= BUSY;
                                cnt_q   <= 4'd1;
                            end
                        end
                        BUSY: begin
                            if (!reqOk || done) begin
                                state_q <= IDLE;
                                cnt_q   <= 4'd0;
                            end else begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Storage is deliberately left out of reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (ByteEnM[i]) begin
                    mem_q[wordIdx][8*i +: 8] <= WriteDataM[8*i +: 8];
                end
            end
        end
    end

    assign ReadDataM = mem_q[wordIdx];

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws: five instances with different WAIT values share one clock and reset.
// Stimulus queues the expected per-cycle response; a negedge monitor pops and compares it.
module tb_dmem_ws;

    typedef struct {
        int          d;
        logic        stall;
        logic        chkData;
        logic [31:0] data;
        logic        chkMis;
        logic        mis;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdS    [5];
    logic        wrS    [5];
    logic [3:0]  beS    [5];
    logic [31:0] adrS   [5];
    logic [31:0] wdatS  [5];
    logic [31:0] rdatS  [5];
    logic        stallS [5];
`ifdef DMEM_MISALIGN_EN
    logic        misS;
`endif

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_ws #(.DEPTH(64), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .MemReadM(rdS[0]), .MemWriteM(wrS[0]), .ByteEnM(beS[0]),
        .DataAdrM(adrS[0]), .WriteDataM(wdatS[0]), .ReadDataM(rdatS[0]), .StallM(stallS[0]));
    dmem_ws #(.DEPTH(64), .WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .MemReadM(rdS[1]), .MemWriteM(wrS[1]), .ByteEnM(beS[1]),
        .DataAdrM(adrS[1]), .WriteDataM(wdatS[1]), .ReadDataM(rdatS[1]), .StallM(stallS[1]));
    dmem_ws #(.DEPTH(64), .WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .MemReadM(rdS[2]), .MemWriteM(wrS[2]), .ByteEnM(beS[2]),
        .DataAdrM(adrS[2]), .WriteDataM(wdatS[2]), .ReadDataM(rdatS[2]), .StallM(stallS[2]));
    dmem_ws #(.DEPTH(64), .WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .MemReadM(rdS[3]), .MemWriteM(wrS[3]), .ByteEnM(beS[3]),
        .DataAdrM(adrS[3]), .WriteDataM(wdatS[3]), .ReadDataM(rdatS[3]), .StallM(stallS[3]));
    dmem_ws #(.DEPTH(64), .WAIT(2)) dut4 (
        .clk(clk), .reset(reset), .MemReadM(rdS[4]), .MemWriteM(wrS[4]), .ByteEnM(beS[4]),
        .DataAdrM(adrS[4]), .WriteDataM(wdatS[4]), .ReadDataM(rdatS[4]), .StallM(stallS[4])
`ifdef DMEM_MISALIGN_EN
        , .MisalignM(misS)
`endif
    );

    // Drive one cycle of inputs to instance d and queue what it must show in that cycle.
    task automatic applyStimulus(input int d, input logic rst, input logic r, input logic w,
                                 input logic [3:0] b, input logic [31:0] a, input logic [31:0] wdat,
                                 input logic expStall, input logic chkData, input logic [31:0] expData,
                                 input logic chkMis, input logic expMis, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        rdS[d]   = r;
        wrS[d]   = w;
        beS[d]   = b;
        adrS[d]  = a;
        wdatS[d] = wdat;
        e.d = d; e.stall = expStall; e.chkData = chkData; e.data = expData;
        e.chkMis = chkMis; e.mis = expMis; e.name = name;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (stallS[e.d] !== e.stall) begin
            failures++;
            $display("[TB] FAIL %s stall dut%0d actual=%b expected=%b", e.name, e.d, stallS[e.d], e.stall);
        end
        if (e.chkData) begin
            checks++;
            if (rdatS[e.d] !== e.data) begin
                failures++;
                $display("[TB] FAIL %s rdata dut%0d actual=%h expected=%h", e.name, e.d, rdatS[e.d], e.data);
            end
        end
`ifdef DMEM_MISALIGN_EN
        if (e.chkMis) begin
            checks++;
            if (misS !== e.mis) begin
                failures++;
                $display("[TB] FAIL %s misalign actual=%b expected=%b", e.name, misS, e.mis);
            end
        end
`endif
    endtask

    task automatic doWrite(input int d, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] v, input logic s, input string name);
        applyStimulus(d, 1'b0, 1'b0, 1'b1, b, a, v, s, 1'b0, 32'h0, 1'b0, 1'b0, name);
    endtask

    task automatic doRead(input int d, input logic [31:0] a, input logic s,
                          input logic chk, input logic [31:0] v, input string name);
        applyStimulus(d, 1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0, s, chk, v, 1'b0, 1'b0, name);
    endtask

    task automatic doIdle(input int d);
        applyStimulus(d, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            rdS[i] = 1'b0; wrS[i] = 1'b0; beS[i] = 4'h0; adrS[i] = 32'h0; wdatS[i] = 32'h0;
        end

        // Reset cycle with a request present: no stall; afterwards the held request starts fresh.
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "rst_stall");
        doRead(2, 32'h10, 1'b1, 1'b0, 32'h0, "post_rst_s1");
        doRead(2, 32'h10, 1'b1, 1'b0, 32'h0, "post_rst_s2");
        doRead(2, 32'h10, 1'b0, 1'b0, 32'h0, "post_rst_done");
        doIdle(2);

        // WAIT=2 word write then back-to-back read.
        doWrite(2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, "w2_wr_s1");
        doWrite(2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, "w2_wr_s2");
        doWrite(2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, "w2_wr_done");
        doRead(2, 32'h10, 1'b1, 1'b0, 32'h0, "w2_rd_s1");
        doRead(2, 32'h10, 1'b1, 1'b0, 32'h0, "w2_rd_s2");
        doRead(2, 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, "w2_rd_done");
        doIdle(2);

        // WAIT=0: never stalls, write visible next cycle.
        doWrite(0, 32'h20, 4'hF, 32'h12345678, 1'b0, "w0_wr");
        doRead(0, 32'h20, 1'b0, 1'b1, 32'h12345678, "w0_rd");
        doIdle(0);

        // WAIT=1: single byte lane merge, then an aliased address wraps onto the same word.
        doWrite(1, 32'h24, 4'hF, 32'h11223344, 1'b1, "w1_pre_s1");
        doWrite(1, 32'h24, 4'hF, 32'h11223344, 1'b0, "w1_pre_done");
        doWrite(1, 32'h24, 4'b0010, 32'h0000AA00, 1'b1, "w1_lane_s1");
        doWrite(1, 32'h24, 4'b0010, 32'h0000AA00, 1'b0, "w1_lane_done");
        doRead(1, 32'h24, 1'b1, 1'b0, 32'h0, "w1_rd_s1");
        doRead(1, 32'h24, 1'b0, 1'b1, 32'h1122AA44, "w1_rd_done");
        doRead(1, 32'h124, 1'b1, 1'b0, 32'h0, "w1_wrap_s1");
        doRead(1, 32'h124, 1'b0, 1'b1, 32'h1122AA44, "w1_wrap_done");
        doIdle(1);

        // WAIT=3: preload, then a write flushed after one stall cycle must not land.
        for (int i = 0; i < 3; i++) doWrite(3, 32'h30, 4'hF, 32'hCAFEF00D, 1'b1, "w3_pre_s");
        doWrite(3, 32'h30, 4'hF, 32'hCAFEF00D, 1'b0, "w3_pre_done");
        doWrite(3, 32'h30, 4'hF, 32'h0BADBEEF, 1'b1, "w3_drop_s1");
        doIdle(3);
        for (int i = 0; i < 3; i++) doRead(3, 32'h30, 1'b1, 1'b0, 32'h0, "w3_rd_s");
        doRead(3, 32'h30, 1'b0, 1'b1, 32'hCAFEF00D, "w3_rd_old");
        doIdle(3);

        // WAIT=3: reset in cycle 2 of a write aborts it; the held request then takes 3 fresh stalls.
        for (int i = 0; i < 3; i++) doWrite(3, 32'h34, 4'hF, 32'h01020304, 1'b1, "w3_pre34_s");
        doWrite(3, 32'h34, 4'hF, 32'h01020304, 1'b0, "w3_pre34_done");
        doWrite(3, 32'h34, 4'hF, 32'h55AA55AA, 1'b1, "w3_rstwr_s1");
        applyStimulus(3, 1'b1, 1'b0, 1'b1, 4'hF, 32'h34, 32'h55AA55AA, 1'b0, 1'b0, 32'h0,
                      1'b0, 1'b0, "w3_rst_cycle");
        for (int i = 0; i < 3; i++)
            applyStimulus(3, 1'b0, 1'b0, 1'b1, 4'hF, 32'h34, 32'h55AA55AA, 1'b1, 1'b1, 32'h01020304,
                          1'b0, 1'b0, "w3_fresh_s");
        doWrite(3, 32'h34, 4'hF, 32'h55AA55AA, 1'b0, "w3_fresh_done");
        doIdle(3);
        for (int i = 0; i < 3; i++) doRead(3, 32'h34, 1'b1, 1'b0, 32'h0, "w3_rd34_s");
        doRead(3, 32'h34, 1'b0, 1'b1, 32'h55AA55AA, "w3_rd34_new");
        doIdle(3);

`ifdef DMEM_MISALIGN_EN
        // Misaligned word write is rejected at once; aligned-enough halfword goes through.
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'hF, 32'h40, 32'h00000000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "mis_pre_s1");
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'hF, 32'h40, 32'h00000000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "mis_pre_s2");
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'hF, 32'h40, 32'h00000000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "mis_pre_done");
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'hF, 32'h42, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "mis_word");
        doIdle(4);
        doRead(4, 32'h40, 1'b1, 1'b0, 32'h0, "mis_rd_s1");
        doRead(4, 32'h40, 1'b1, 1'b0, 32'h0, "mis_rd_s2");
        doRead(4, 32'h40, 1'b0, 1'b1, 32'h00000000, "mis_rd_unchanged");
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h42, 32'hBEEF0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "half_s1");
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h42, 32'hBEEF0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, "half_s2");
        applyStimulus(4, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h42, 32'hBEEF0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "half_done");
        doIdle(4);
        doRead(4, 32'h40, 1'b1, 1'b0, 32'h0, "half_rd_s1");
        doRead(4, 32'h40, 1'b1, 1'b0, 32'h0, "half_rd_s2");
        doRead(4, 32'h40, 1'b0, 1'b1, 32'hBEEF0000, "half_rd_done");
        doIdle(4);
`endif

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
